shift_seq_ctrl: RTL
===================

// Module: shift_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the Gumnut shift/rotate unit: accepts one shift request via valid/ready,
//  performs it iteratively one bit position per cycle, returns result + carry via valid/ready.
//  Sits between instruction decode/execute control and the register-file writeback path.
//  Result and carry match the combinational shift unit for every op/count combination.
// PARAMETERS
//  DATA_W  8               operand/result width in bits
//  CNT_W   $clog2(DATA_W)  shift-count width; cnt_in range 0..DATA_W-1
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       = (state==IDLE) && rst_n
//  a_in       in   DATA_W  operand
//  cnt_in     in   CNT_W   shift count
//  op_in      in   2       00 shl, 01 shr, 10 rol, 11 ror
//  abort      in   1       synchronous cancel of in-flight op
//  busy       out  1       state != IDLE
//  res_valid  out  1       result available (state==DONE)
//  res_ready  in   1       consumer accepts result
//  result     out  DATA_W  shifted value (registered)
//  carry      out  1       carry flag (registered)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, result=0, carry=0, remaining count=0, res_valid=0, busy=0.
//  States IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: on req_valid&&req_ready capture a_in/op_in into result/op regs, cnt_in into counter, carry=0
//   -> SHIFT if cnt_in!=0, else -> DONE (rotate ops: carry set per rule below on that DONE entry).
//  SHIFT: one bit per cycle, counter decrements; leave for DONE when counter reaches 0.
//   shl: carry<=result[DATA_W-1], result<=result<<1 (zero fill)
//   shr: carry<=result[0],        result<=result>>1 (zero fill)
//   rol: result<={result[DATA_W-2:0],result[DATA_W-1]}; ror: {result[0],result[DATA_W-1:1]}
//  Entering DONE: rol carry=final result[0]; ror carry=final result[DATA_W-1];
//   shl/shr carry = last bit shifted out, 0 when count=0.
//  Latency: res_valid rises cnt+1 cycles after the accepting edge (count 0 -> 1 cycle).
//  DONE: res_valid=1, result/carry held stable until res_ready=1; that edge -> IDLE.
//   req_ready=0 in DONE, so a new request is accepted no earlier than the cycle after the result handshake.
//  abort=1 in SHIFT or DONE: -> IDLE next edge, res_valid deasserts, no result handshake; result/carry
//   keep partial values (don't-care). abort in IDLE: ignored; abort has priority over res_ready.
//  Inputs a_in/cnt_in/op_in ignored outside the accepting cycle; changes mid-op have no effect.
//  rst_n low mid-operation: op discarded, outputs to reset values immediately.
// CONFIGURATION
//  SHIFT_ZERO_FLAG_EN defined: extra output port zero (1 bit), registered, =1 iff result==0 in DONE;
//   0 in all other states and at reset.
//  Not defined: port zero absent; all other behaviour identical.
// TESTING
//  shl a=0x81 cnt=1, res_ready=1 -> result=0x02 carry=1, res_valid 2 cycles after accept.
//  shr a=0x81 cnt=3 -> result=0x10 carry=0 after 4 cycles; shr a=0x84 cnt=3 -> 0x10 carry=1.
//  rol a=0x81 cnt=4 -> result=0x18 carry=0; ror a=0x01 cnt=1 -> result=0x80 carry=1.
//  cnt=0: shl a=0xFF -> result=0xFF carry=0, 1-cycle latency; rol a=0xFF cnt=0 -> 0xFF carry=1.
//  Backpressure: res_ready=0 for 5 cycles in DONE -> result/carry stable, req_ready=0, busy=1;
//   res_ready=1 -> IDLE next edge, back-to-back request accepted the following cycle.
//  abort at 3rd SHIFT cycle of cnt=7 op -> IDLE next edge, no res_valid; rst_n pulse mid-SHIFT
//   -> result=0 carry=0 res_valid=0 immediately; with SHIFT_ZERO_FLAG_EN shl 0x80 cnt=1 -> zero=1.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: iterative shift/rotate sequencer (one bit position per cycle) with valid/ready on both sides.
// Optional feature: define SHIFT_ZERO_FLAG_EN to add the registered 'zero' output (result==0 while in DONE).
module shift_seq_ctrl #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] a_in,
   input  logic [CNT_W-1:0]  cnt_in,
   input  logic [1:0]        op_in,
   input  logic              abort,
   output logic              busy,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] result,
   output logic              carry
`ifdef SHIFT_ZERO_FLAG_EN
   ,
   output logic              zero
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_SHL = 2'd0,
      OP_SHR = 2'd1,
      OP_ROL = 2'd2,
      OP_ROR = 2'd3
   } op_t;

   state_t            state, state_nxt;
   op_t               op_q, op_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt;
   logic [DATA_W-1:0] result_nxt;
   logic              carry_nxt;
   logic [DATA_W-1:0] step_res;
   logic              step_out;

   assign req_ready = (state == IDLE) && rst_n;
   assign busy      = (state != IDLE);
   assign res_valid = (state == DONE);

   // One-position step. The bit leaving the MSB/LSB is the shift carry and, for rotates,
   // also the bit landing at the opposite end, which is exactly the carry rule on DONE entry.
   always_comb begin
      step_res = result;
      step_out = 1'b0;
      case (op_q)
         OP_SHL: begin
            step_res = {result[DATA_W-2:0], 1'b0};
            step_out = result[DATA_W-1];
         end
         OP_SHR: begin
            step_res = {1'b0, result[DATA_W-1:1]};
            step_out = result[0];
         end
         OP_ROL: begin
            step_res = {result[DATA_W-2:0], result[DATA_W-1]};
            step_out = result[DATA_W-1];
         end
         OP_ROR: begin
            step_res = {result[0], result[DATA_W-1:1]};
            step_out = result[0];
         end
         default: begin
            step_res = result;
            step_out = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_nxt  = state;
      op_nxt     = op_q;
      cnt_nxt    = cnt_q;
      result_nxt = result;
      carry_nxt  = carry;
      case (state)
         IDLE: begin
            if (req_valid) begin
               op_nxt     = op_t'(op_in);
               cnt_nxt    = cnt_in;
               result_nxt = a_in;
               carry_nxt  = 1'b0;
               if (cnt_in == '0) begin
                  state_nxt = DONE;
                  case (op_t'(op_in))
                     OP_ROL:  carry_nxt = a_in[0];
                     OP_ROR:  carry_nxt = a_in[DATA_W-1];
                     default: carry_nxt = 1'b0;
                  endcase
               end else begin
                  state_nxt = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               result_nxt = step_res;
               carry_nxt  = step_out;
               cnt_nxt    = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            if (abort || res_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         op_q   <= OP_SHL;
         cnt_q  <= '0;
         result <= '0;
         carry  <= 1'b0;
      end else begin
         state  <= state_nxt;
         op_q   <= op_nxt;
         cnt_q  <= cnt_nxt;
         result <= result_nxt;
         carry  <= carry_nxt;
      end
   end

`ifdef SHIFT_ZERO_FLAG_EN
   // Registered alongside result so the flag is valid in the same cycle as res_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero <= 1'b0;
      end else begin
         zero <= (state_nxt == DONE) && (result_nxt == '0);
      end
   end
`endif

endmodule
